// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit-PC MIPS datapath: sequences fetch/decode/execute
// over a shared ALU and memory port, with req/ack memory timeout, illegal-opcode trap and retire counter.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             clear_trap,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             memto_reg,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               retire;
    logic               timeout_hit;

    // Branch resolution happens in the datapath through pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wait_q        <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        memto_reg     = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ack)          state_d = S_MEM_WB;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                memto_reg = 1'b1;
                retire    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ack)          retire  = 1'b1;
                else if (timeout_hit) state_d = S_TRAP;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
                retire        = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
                retire   = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
                if (clear_trap) state_d = S_IDLE;
            end
            default: state_d = S_TRAP;
        endcase

        // run is only consulted at instruction boundaries
        if (retire) state_d = run ? S_FETCH : S_IDLE;
    end

    // Wait counter restarts whenever the FSM changes state, so each access gets a fresh budget.
    always_comb begin
        wait_d = '0;
        if ((state_d == state_q) && mem_req && !mem_ack) wait_d = wait_q + WAIT_W'(1);
    end

    always_comb begin
        instr_count_d = instr_count_q;
        if (retire) instr_count_d = instr_count_q + CNT_W'(1);
    end

    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the existing 16-bit-PC MIPS datapath (register file, ALU, ALU control, shared memory).
- Replaces the single-cycle decode, so one ALU and one memory port are reused across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Adds a req/ack memory handshake with timeout, an illegal-opcode trap, and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- TIMEOUT, 8, max cycles mem_req may wait for mem_ack before trapping (range 1..255)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- run  in  1  level; allows leaving IDLE and starting the next instruction
- clear_trap  in  1  leave TRAP to IDLE
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write request (valid with mem_req)
- iord  out  1  0 = PC addresses memory, 1 = ALUOut
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero=1
- pc_src  out  2  0 = ALU, 1 = ALUOut, 2 = jump target
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2
- alu_op  out  2  to ALU control: 0 = add, 1 = sub, 2 = funct
- reg_write, reg_dst, memto_reg  out  1 each  register-file write controls
- state  out  4  current state encoding
- illegal  out  1  high while in TRAP
- instr_count  out  CNT_W  retired instructions

Behaviour:
- Reset (async): state = IDLE, instr_count = 0, wait counter = 0. All control outputs are 0 while in IDLE.
- State encoding:
  - IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6
  - EXEC_R=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=13
  - Unused codes go to TRAP.
- Outputs are Moore (decoded from state), except ir_write/pc_write in FETCH, which are gated by mem_ack.
- IDLE: go to FETCH when run=1.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - On mem_ack: ir_write=1 and pc_write=1 for exactly that cycle (PC += 4), then DECODE.
  - Without mem_ack: stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDI_EX
  - any other -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: MEM_RD if opcode=0x23, else MEM_WR.
- MEM_RD: mem_req=1, iord=1, mem_we=0. Go to MEM_WB on mem_ack.
- MEM_WB: reg_write=1, reg_dst=0, memto_reg=1.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Completes on mem_ack.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2. Then R_WB.
- R_WB: reg_write=1, reg_dst=1, memto_reg=0.
- ADDI_EX: alu_src_a=1, alu_src_b=2, alu_op=0. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, memto_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1.
- JUMP: pc_write=1, pc_src=2.
- Retire states are MEM_WB, MEM_WR (on ack), R_WB, ADDI_WB, BRANCH, JUMP:
  - instr_count += 1, wrapping modulo 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
  - run is not sampled mid-instruction; deasserting run finishes the current instruction.
- Cycle counts (zero-wait memory): R/addi/lw = 4/4/5 cycles, sw = 4, beq/j = 3.
- Memory wait:
  - The wait counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle mem_req=1 with mem_ack=0.
  - On reaching TIMEOUT without ack: go to TRAP; mem_req drops the next cycle.
  - If mem_ack arrives in the same cycle the counter hits TIMEOUT, the ack wins.
- mem_ack while mem_req=0 is ignored.
- TRAP: all controls 0, illegal=1, instr_count frozen. Go to IDLE on clear_trap=1; if clear_trap and run are both 1, IDLE is still visited for one cycle.
- reset mid-instruction: immediate return to IDLE; any partial memory transaction is abandoned with mem_req=0.

Test Plan:
- Reset, run=1, opcode=0x00, mem_ack tied 1 -> states 1,2,7,8,1. ir_write and pc_write high in cycle 1 only. reg_write=1 with reg_dst=1 in R_WB. instr_count=1.
- lw (0x23) with mem_ack delayed 3 cycles in MEM_RD -> mem_req held 4 cycles, iord=1, then MEM_WB with memto_reg=1. instr_count increments once.
- beq (0x04) with zero=1, then zero=0 -> pc_write_cond=1 and pc_src=1 in BRANCH both times; state returns to FETCH after 3 cycles.
- Opcode 0x3F -> TRAP, illegal=1, instr_count unchanged. clear_trap=1 -> IDLE next cycle.
- TIMEOUT=8 with mem_ack never asserted in FETCH -> TRAP after 8 waiting cycles. Repeat with ack on the 8th cycle -> DECODE.
- Async reset asserted during MEM_WR with mem_req=1 -> state=0, mem_req=0 and mem_we=0 immediately. run=0 at an R_WB retire -> IDLE.
